// File: rtl/spm_pkg.sv
// Shared types and helpers for the serial-parallel multiplier.
package spm_pkg;

    localparam int SPM_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } spm_state_e;

    // Bit-counter width, sized to count 0..2*width-1.
    function automatic int spm_cnt_w(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/spm_csa_cell.sv
// One carry-save adder cell: adds its partial product, the sum of the next
// cell up and its own stored carry.
module spm_csa_cell (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic restart,
    input  logic x_bit,
    input  logic y_bit,
    input  logic s_in,
    output logic sum
);

    logic carry;
    logic pp;

    assign pp = x_bit & y_bit;

    // NOTE: sequential state uses non-blocking assignments so every cell samples
    // its neighbour's old sum, which is what turns the chain into a shift.
    always_ff @(posedge clk) begin
        if (clr) begin
            sum   <= 1'b0;
            carry <= 1'b0;
        end else if (en) begin
            if (restart) begin
                // First step of a new operation: the chain is treated as empty.
                sum   <= pp;
                carry <= 1'b0;
            end else begin
                sum   <= pp ^ s_in ^ carry;
                carry <= (pp & s_in) | (pp & carry) | (s_in & carry);
            end
        end
    end

endmodule

// File: rtl/spm_serial_mul.sv
// Serial-parallel multiplier with valid/ready handshakes: x in parallel, y one
// bit per cycle LSB first, product emitted serially and collected in parallel.
module spm_serial_mul
    import spm_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 p,
    output logic                 p_valid,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int N  = WIDTH + ((SIGNED != 0) ? 1 : 0);
    localparam int PW = 2 * WIDTH;
    localparam int CW = spm_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(PW - 1);

    if (WIDTH < 2 || WIDTH > SPM_MAX_WIDTH) begin : g_bad_width
        $error("spm_serial_mul: WIDTH out of range");
    end

    spm_state_e        state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [N-1:0]      x_q, x_ext, x_op, cell_sum, s_chain;
    logic [WIDTH-1:0]  y_sh;
    logic              in_hs, out_hs, chain_en, y_bit, y_fill, run_fill;

    assign in_hs    = in_valid & in_ready;
    assign out_hs   = out_valid & out_ready;
    assign y_fill   = (SIGNED != 0) ? y[WIDTH-1] : 1'b0;
    assign run_fill = (SIGNED != 0) ? y_sh[WIDTH-1] : 1'b0;

    // Step 0 runs on the handshake edge straight from the ports, so bit k of
    // the result sits in cell 0 during RUN cycle k.
    assign y_bit    = in_hs ? y[0] : y_sh[0];
    assign x_op     = in_hs ? x_ext : x_q;
    assign chain_en = in_hs | ((state == RUN) && (cnt != LAST));
    assign p        = cell_sum[0];

    if (SIGNED != 0) begin : g_sext
        assign x_ext = {x[WIDTH-1], x};
    end else begin : g_zext
        assign x_ext = x;
    end

    for (genvar i = 0; i < N; i++) begin : g_cell
        if (i == N - 1) begin : g_top
            // Signed mode sign-extends the top sum on every right shift.
            assign s_chain[i] = (SIGNED != 0) ? cell_sum[i] : 1'b0;
        end else begin : g_mid
            assign s_chain[i] = cell_sum[i+1];
        end

        spm_csa_cell u_cell (
            .clk     (clk),
            .clr     (rst),
            .en      (chain_en),
            .restart (in_hs),
            .x_bit   (x_op[i]),
            .y_bit   (y_bit),
            .s_in    (s_chain[i]),
            .sum     (cell_sum[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: the next-state default is assigned first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_hs) state_nxt = RUN;
            RUN:  if (cnt == LAST) state_nxt = DONE;
            DONE: if (out_hs) state_nxt = in_hs ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            x_q     <= '0;
            y_sh    <= '0;
            product <= '0;
            p_valid <= 1'b0;
        end else begin
            p_valid <= (state_nxt == RUN);
            if (in_hs) begin
                cnt     <= '0;
                x_q     <= x_ext;
                y_sh    <= {y_fill, y[WIDTH-1:1]};
                product <= '0;
            end else if (state == RUN) begin
                if (cnt != LAST) cnt <= cnt + 1'b1;
                y_sh    <= {run_fill, y_sh[WIDTH-1:1]};
                product <= {p, product[PW-1:1]};
            end
        end
    end

endmodule

// File: doc/spm_serial_mul.md
Name: spm_serial_mul

Overview:
- Parametrised successor to the fixed 32-bit serial-parallel multiplier (spm).
- Multiplicand x is loaded in parallel. Multiplier y is consumed one bit per cycle, LSB first, through a chain of carry-save adder cells.
- The product is emitted serially, LSB first, and also collected into a parallel result register.
- Adds three things the fixed version lacks: valid/ready handshakes on input and output, configurable width, and a two's-complement signed mode.

Parameters:
- WIDTH, 32, operand width in bits; legal range 2..64.
- SIGNED, 0, 0 = unsigned x*y; 1 = two's-complement x*y.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block accepts an operand pair this cycle.
- x  in  WIDTH  multiplicand, sampled on input handshake.
- y  in  WIDTH  multiplier, sampled on input handshake.
- p  out  1  serial product bit.
- p_valid  out  1  p carries a product bit this cycle.
- out_valid  out  1  product holds a complete result.
- out_ready  in  1  downstream accepts product.
- product  out  2*WIDTH  parallel result.
- busy  out  1  state != IDLE.

Behaviour:
- Handshakes:
  - Input handshake = in_valid & in_ready.
  - Output handshake = out_valid & out_ready.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on input handshake. x, y and sign mode are latched; the carry-save chain and bit counter are cleared.
  - RUN lasts exactly 2*WIDTH cycles; the counter runs 0..2*WIDTH-1. In cycle k the chain is fed y_bit(k):
    - for k < WIDTH, y[k];
    - for k >= WIDTH, y[WIDTH-1] if SIGNED, else 0.
  - RUN -> DONE after counter reaches 2*WIDTH-1.
  - DONE -> IDLE on output handshake without a new input handshake.
  - DONE -> RUN on output handshake with a simultaneous input handshake (back-to-back).
- in_ready = (state==IDLE) | (state==DONE & out_ready). in_valid in RUN is ignored and operands are not sampled.
- Serial output and latency:
  - p and p_valid are registered.
  - p_valid is high for exactly 2*WIDTH consecutive cycles, starting the cycle after the input handshake.
  - On the k-th of those cycles (k from 0), p = bit k of the result.
- Result register:
  - product shifts in each p bit at bit position k.
  - product is stable from the first cycle of DONE until the next input handshake.
  - out_valid = (state==DONE), asserted the cycle after the last p_valid cycle.
  - Total latency from input handshake to out_valid is 2*WIDTH+1 cycles.
- Arithmetic:
  - Result = x*y mod 2^(2*WIDTH), with operands read as unsigned or two's complement per SIGNED.
  - The chain has WIDTH cells (SIGNED=0) or WIDTH+1 cells (SIGNED=1, x sign-extended to WIDTH+1 bits). The top cell's sum/carry are sign-extended on each right shift.
  - Cell i: sum = pp_i ^ s_{i+1} ^ c_i, carry = majority(pp_i, s_{i+1}, c_i), with pp_i = x_i & y_bit.
  - No bit is lost for the full range of operand values. SIGNED=1 must give the correct result for -2^(WIDTH-1) in both operands.
- Backpressure: out_ready low in DONE holds product and out_valid indefinitely; p_valid stays 0.
- Reset:
  - rst in any state, including mid-RUN: next state IDLE, chain, counter and product cleared, partial result discarded.
  - Reset values: in_ready=1 (comb, IDLE), p=0, p_valid=0, out_valid=0, product=0, busy=0.
  - rst has priority over every handshake in the same cycle.

Decomposition:
- Package spm_pkg:
  - typedef enum {IDLE, RUN, DONE} spm_state_e;
  - function spm_cnt_w(WIDTH) = $clog2(2*WIDTH) for the counter width;
  - SPM_MAX_WIDTH = 64 constant.
- One natural sub-module, spm_csa_cell: one carry-save cell with registered sum and carry, synchronous clear input, generated WIDTH or WIDTH+1 times.
- FSM, counter, sign-extension and result shift register stay in spm_serial_mul.

Test Plan:
- WIDTH=8, SIGNED=0, x=3, y=5, out_ready=1 -> p_valid for 16 cycles, p sequence LSB-first of 0x000F, out_valid at cycle 17, product=0x000F.
- WIDTH=8, SIGNED=0, x=0xFF, y=0xFF -> product=0xFE01; then x=0, y=0xA5 -> product=0x0000.
- WIDTH=8, SIGNED=1:
  - x=0xFF, y=0xFF -> 0x0001;
  - x=0x80, y=0x7F -> 0xC080;
  - x=0x80, y=0x80 -> 0x4000.
- Backpressure/back-to-back: hold out_ready=0 for 5 cycles in DONE -> product and out_valid stable, in_ready=0. Then out_ready=1 with in_valid=1 (x=2, y=7) -> handshakes in the same cycle, next product=0x000E after 17 cycles, no idle gap.
- Reset mid-RUN: assert rst at RUN cycle 6 of x=0x55, y=0x33 -> next cycle IDLE, all outputs at reset values. A following x=1, y=1 yields product=0x0001 with no residue.
- Randomised WIDTH=32, both SIGNED values, 1000 pairs with random out_ready stalls and in_valid during RUN -> every product matches the reference model, and each p stream equals its product bits.
